// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam logic [0:0] ST_RUN       = 1'b0;
  localparam logic [0:0] ST_LONG_WAIT = 1'b1;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_hold;
    logic ex_hold;
  } ctrl_t;

  // Canonical control-output patterns
  localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                    id_ex_bubble: 1'b1, id_ex_hold: 1'b0, ex_hold: 1'b0};
  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b0, id_ex_hold: 1'b0, ex_hold: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b0, id_ex_hold: 1'b1, ex_hold: 1'b1};
  localparam ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b0, if_id_flush: 1'b1,
                                    id_ex_bubble: 1'b1, id_ex_hold: 1'b0, ex_hold: 1'b0};
  localparam ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b1, id_ex_hold: 1'b0, ex_hold: 1'b0};

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall-cycle and branch-flush performance counters; wrap at 2^CNT_W.
module hazard_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pc_write,
  input  logic             if_id_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write)  stall_cycles <= stall_cycles + CNT_W'(1);
      if (if_id_flush) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use, branch flush, multi-cycle EX, mem stall.
// Perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int unsigned LONG_LAT = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_long_start,
  input  logic             mem_stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic             ex_hold,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  import hazard_ctrl_pkg::*;

  localparam int unsigned CNT_BITS = $clog2(LONG_LAT);

  logic [0:0]          state, state_nxt;
  logic [CNT_BITS-1:0] cnt, cnt_nxt;
  logic                load_use;
  ctrl_t               ctrl;

  // x0 never produces a hazard
  assign load_use = idex_mem_read && (idex_rd != REG_X0) &&
                    ((id_use_rs1 && (id_rs1 == idex_rd)) ||
                     (id_use_rs2 && (id_rs2 == idex_rd)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Fixed-priority hazard resolution; the release cycle of a long op gives plain RUN outputs
  always_comb begin
    ctrl      = CTRL_RUN;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!reset_n) begin
      ctrl = CTRL_RESET;
    end else if (mem_stall) begin
      ctrl = CTRL_FREEZE;
    end else if (state == ST_LONG_WAIT) begin
      if (cnt == '0) begin
        state_nxt = ST_RUN;
      end else begin
        ctrl    = CTRL_FREEZE;
        cnt_nxt = cnt - CNT_BITS'(1);
      end
    end else if (ex_branch_taken) begin
      ctrl = CTRL_FLUSH;
    end else if (ex_long_start) begin
      ctrl      = CTRL_FREEZE;
      state_nxt = ST_LONG_WAIT;
      cnt_nxt   = CNT_BITS'(LONG_LAT - 2);
    end else if (load_use) begin
      ctrl = CTRL_BUBBLE;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign id_ex_hold   = ctrl.id_ex_hold;
  assign ex_hold      = ctrl.ex_hold;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc_write     (pc_write),
    .if_id_flush  (if_id_flush),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
